// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_ERR      = 4'd14
    } state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_RTYPE, ALU_ITYPE, ALU_BRANCH} aluop_t;

    localparam logic [3:0] ALUC_AND  = 4'h0;
    localparam logic [3:0] ALUC_OR   = 4'h1;
    localparam logic [3:0] ALUC_ADD  = 4'h2;
    localparam logic [3:0] ALUC_SLTU = 4'h3;
    localparam logic [3:0] ALUC_SLT  = 4'h4;
    localparam logic [3:0] ALUC_BLTU = 4'h5;
    localparam logic [3:0] ALUC_SUB  = 4'h6;
    localparam logic [3:0] ALUC_BGEU = 4'h7;
    localparam logic [3:0] ALUC_SLL  = 4'h8;
    localparam logic [3:0] ALUC_XOR  = 4'h9;
    localparam logic [3:0] ALUC_SRL  = 4'hA;
    localparam logic [3:0] ALUC_SRA  = 4'hB;
    localparam logic [3:0] ALUC_BEQ  = 4'hC;
    localparam logic [3:0] ALUC_BNE  = 4'hD;
    localparam logic [3:0] ALUC_BLT  = 4'hE;
    localparam logic [3:0] ALUC_BGE  = 4'hF;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format is a pure function of the opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        logic [2:0] imm;
        case (opcode)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Control-unit interface: IR fields and handshake in, datapath controls out.
interface rv_multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Comparison;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic [3:0] ALUCtrl;
    logic       illegal;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct3, funct7b5, Comparison, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUCtrl, illegal, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7b5, Comparison, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUCtrl, illegal, state_dbg
    );
endinterface

// File: rtl/rv_alu_decoder.sv
// Maps the FSM's coarse ALU intent plus funct fields to the 4-bit ALU code.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  aluop_t     i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic [3:0] o_aluctrl
);

    // Combinational code selection; immediate ops never subtract.
    always_comb begin
        o_aluctrl = ALUC_ADD;
        case (i_aluop)
            ALU_RTYPE, ALU_ITYPE: begin
                case (i_funct3)
                    3'b000: begin
                        if ((i_aluop == ALU_RTYPE) && i_funct7b5) o_aluctrl = ALUC_SUB;
                        else                                      o_aluctrl = ALUC_ADD;
                    end
                    3'b001: o_aluctrl = ALUC_SLL;
                    3'b010: o_aluctrl = ALUC_SLT;
                    3'b011: o_aluctrl = ALUC_SLTU;
                    3'b100: o_aluctrl = ALUC_XOR;
                    3'b101: begin
                        if (i_funct7b5) o_aluctrl = ALUC_SRA;
                        else            o_aluctrl = ALUC_SRL;
                    end
                    3'b110: o_aluctrl = ALUC_OR;
                    3'b111: o_aluctrl = ALUC_AND;
                    default: o_aluctrl = ALUC_ADD;
                endcase
            end
            ALU_BRANCH: begin
                case (i_funct3)
                    3'b000: o_aluctrl = ALUC_BEQ;
                    3'b001: o_aluctrl = ALUC_BNE;
                    3'b100: o_aluctrl = ALUC_BLT;
                    3'b101: o_aluctrl = ALUC_BGE;
                    3'b110: o_aluctrl = ALUC_BLTU;
                    3'b111: o_aluctrl = ALUC_BGEU;
                    default: o_aluctrl = ALUC_ADD;
                endcase
            end
            default: o_aluctrl = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main Moore control FSM of the multicycle RV32I core.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rv_multicycle_ctrl_if.master   bus
);

    state_t     r_state;
    state_t     w_next;
    aluop_t     w_aluop;
    logic       w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite, w_illegal;
    logic [1:0] w_resultsrc, w_srca, w_srcb;
    logic [3:0] w_aluctrl;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_next      = r_state;
        w_pcwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_resultsrc = RES_ALUOUT;
        w_srca      = SRCA_PC;
        w_srcb      = SRCB_RS2;
        w_aluop     = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_srcb      = SRCB_FOUR;
                w_resultsrc = RES_ALURESULT;
                w_irwrite   = bus.mem_ready;
                w_pcwrite   = bus.mem_ready;
                if (bus.mem_ready) w_next = S_DECODE;
                else               w_next = S_FETCH;
            end
            S_DECODE: begin
                // Branch/JAL target is precomputed here into ALUOut.
                w_srca = SRCA_OLDPC;
                w_srcb = SRCB_IMM;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXECR;
                    OP_IMM:            w_next = S_EXECI;
                    OP_BRANCH: begin
                        if ((bus.funct3 == 3'b010) || (bus.funct3 == 3'b011)) w_next = S_ERR;
                        else                                                  w_next = S_BRANCH;
                    end
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    default:           w_next = S_ERR;
                endcase
            end
            S_MEMADR: begin
                w_srca = SRCA_RS1;
                w_srcb = SRCB_IMM;
                if (bus.opcode == OP_LOAD) w_next = S_MEMREAD;
                else                       w_next = S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                if (bus.mem_ready) w_next = S_MEMWB;
                else               w_next = S_MEMREAD;
            end
            S_MEMWB: begin
                w_resultsrc = RES_DATA;
                w_regwrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                if (bus.mem_ready) w_next = S_FETCH;
                else               w_next = S_MEMWRITE;
            end
            S_EXECR: begin
                w_srca  = SRCA_RS1;
                w_aluop = ALU_RTYPE;
                w_next  = S_ALUWB;
            end
            S_EXECI: begin
                w_srca  = SRCA_RS1;
                w_srcb  = SRCB_IMM;
                w_aluop = ALU_ITYPE;
                w_next  = S_ALUWB;
            end
            S_LUI: begin
                w_srca = SRCA_ZERO;
                w_srcb = SRCB_IMM;
                w_next = S_ALUWB;
            end
            S_AUIPC: begin
                w_srca = SRCA_OLDPC;
                w_srcb = SRCB_IMM;
                w_next = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                w_srca    = SRCA_RS1;
                w_aluop   = ALU_BRANCH;
                w_pcwrite = bus.Comparison;
                w_next    = S_FETCH;
            end
            S_JALR: begin
                // Target from A latched in DECODE, so rd == rs1 is harmless.
                w_srca = SRCA_RS1;
                w_srcb = SRCB_IMM;
                w_next = S_JAL;
            end
            S_JAL: begin
                // Jump to ALUOut while OldPC + 4 becomes the link value.
                w_pcwrite = 1'b1;
                w_srca    = SRCA_OLDPC;
                w_srcb    = SRCB_FOUR;
                w_next    = S_ALUWB;
            end
            S_ERR: begin
                w_illegal = 1'b1;
                if (ILLEGAL_HALT) w_next = S_ERR;
                else              w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    rv_alu_decoder u_alu_dec (
        .i_aluop    (w_aluop),
        .i_funct3   (bus.funct3),
        .i_funct7b5 (bus.funct7b5),
        .o_aluctrl  (w_aluctrl)
    );

    // Strobes are forced low while reset is held, even if mem_ready is high.
    assign bus.PCWrite   = w_pcwrite  & rst_n;
    assign bus.MemWrite  = w_memwrite & rst_n;
    assign bus.IRWrite   = w_irwrite  & rst_n;
    assign bus.RegWrite  = w_regwrite & rst_n;
    assign bus.illegal   = w_illegal  & rst_n;
    assign bus.AdrSrc    = w_adrsrc;
    assign bus.ResultSrc = w_resultsrc;
    assign bus.ALUSrcA   = w_srca;
    assign bus.ALUSrcB   = w_srcb;
    assign bus.ImmSrc    = imm_src_of(bus.opcode);
    assign bus.ALUCtrl   = w_aluctrl;
    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl with a phase-list reference model.
module tb_rv_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
    localparam logic [6:0] T_IMM = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;
    localparam logic [6:0] T_FENCE = 7'b0001111, T_SYS = 7'b1110011;

    // ALU codes indexed by funct3 (base op, before funct7b5 variants)
    localparam logic [3:0] RTAB [8] = '{4'h2, 4'h8, 4'h4, 4'h3, 4'h9, 4'hA, 4'h1, 4'h0};
    localparam logic [3:0] BTAB [8] = '{4'hC, 4'hD, 4'h2, 4'h2, 4'hE, 4'hF, 4'h5, 4'h7};

    typedef enum {P_FETCH, P_DEC, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXR, P_EXI,
                  P_ALUWB, P_BR, P_JAL, P_JALR, P_LUI, P_AUIPC, P_ERR} ph_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, mw, irw, rw, ill, adr;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [3:0] aluc;
        logic [4:0] care;   // [0]adr [1]rs [2]sa [3]sb [4]imm
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, rst1_n;
    always #5 clk = ~clk;

    rv_multicycle_ctrl_if bus0 ();
    rv_multicycle_ctrl_if bus1 ();

    rv_multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n),  .bus(bus0));
    rv_multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

    int    checks = 0;
    int    errors = 0;
    exp_t  q [$];
    string nq [$];
    exp_t  m_e;
    string m_n;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [2:0] imm_ref(input logic [6:0] opc, output logic known);
        known = 1'b1;
        if (opc == T_LOAD || opc == T_JALR || opc == T_IMM) return 3'd0;
        if (opc == T_STORE) return 3'd1;
        if (opc == T_BR)    return 3'd2;
        if (opc == T_JAL)   return 3'd3;
        if (opc == T_LUI || opc == T_AUIPC) return 3'd4;
        known = 1'b0;
        return 3'd0;
    endfunction

    // Expected controls for one cycle of a given phase.
    function automatic exp_t model(input ph_t p, input logic [6:0] opc, input logic [2:0] f3,
                                   input logic f7, input logic cmp, input logic mr);
        exp_t e;
        logic known;
        e = '0;
        e.aluc = 4'h2;
        e.imm = imm_ref(opc, known);
        e.care[4] = known;
        case (p)
            P_FETCH:  begin e.st = S_FETCH; e.sb = 2'd2; e.rs = 2'd2; e.care[3:0] = 4'b1111;
                            e.irw = mr; e.pcw = mr; end
            P_DEC:    begin e.st = S_DECODE; e.sa = 2'd1; e.sb = 2'd1; e.care[3:0] = 4'b1100; end
            P_MEMADR: begin e.st = S_MEMADR; e.sa = 2'd2; e.sb = 2'd1; e.care[3:0] = 4'b1100; end
            P_MEMRD:  begin e.st = S_MEMREAD; e.adr = 1'b1; e.care[3:0] = 4'b0011; end
            P_MEMWB:  begin e.st = S_MEMWB; e.rs = 2'd1; e.rw = 1'b1; e.care[3:0] = 4'b0010; end
            P_MEMWR:  begin e.st = S_MEMWRITE; e.adr = 1'b1; e.mw = 1'b1; e.care[3:0] = 4'b0011; end
            P_EXR:    begin e.st = S_EXECR; e.sa = 2'd2; e.care[3:0] = 4'b1100;
                            e.aluc = (f3 == 3'd0 && f7) ? 4'h6 : (f3 == 3'd5 && f7) ? 4'hB : RTAB[f3]; end
            P_EXI:    begin e.st = S_EXECI; e.sa = 2'd2; e.sb = 2'd1; e.care[3:0] = 4'b1100;
                            e.aluc = (f3 == 3'd5 && f7) ? 4'hB : RTAB[f3]; end
            P_LUI:    begin e.st = S_LUI; e.sa = 2'd3; e.sb = 2'd1; e.care[3:0] = 4'b1100; end
            P_AUIPC:  begin e.st = S_AUIPC; e.sa = 2'd1; e.sb = 2'd1; e.care[3:0] = 4'b1100; end
            P_ALUWB:  begin e.st = S_ALUWB; e.rw = 1'b1; e.care[3:0] = 4'b0010; end
            P_BR:     begin e.st = S_BRANCH; e.sa = 2'd2; e.pcw = cmp; e.aluc = BTAB[f3];
                            e.care[3:0] = 4'b1110; end
            P_JALR:   begin e.st = S_JALR; e.sa = 2'd2; e.sb = 2'd1; e.care[3:0] = 4'b1100; end
            P_JAL:    begin e.st = S_JAL; e.pcw = 1'b1; e.sa = 2'd1; e.sb = 2'd2; e.care[3:0] = 4'b1110; end
            default:  begin e.st = S_ERR; e.ill = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic step(input string nm, input ph_t p, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic cmp, input logic mr);
        @(posedge clk);
        #1;
        bus0.opcode = opc; bus0.funct3 = f3; bus0.funct7b5 = f7;
        bus0.Comparison = cmp; bus0.mem_ready = mr;
        q.push_back(model(p, opc, f3, f7, cmp, mr));
        nq.push_back(nm);
    endtask

    // One whole instruction: build its phase sequence from the instruction class.
    task automatic run_instr(input string nm, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic cmp, input int fw, input int mw);
        logic r;
        for (int i = 0; i < fw; i++) step(nm, P_FETCH, opc, f3, f7, cmp, 1'b0);
        step(nm, P_FETCH, opc, f3, f7, cmp, 1'b1);
        r = 1'($urandom_range(0, 1));
        step(nm, P_DEC, opc, f3, f7, cmp, r);
        if (opc == T_LOAD) begin
            step(nm, P_MEMADR, opc, f3, f7, cmp, r);
            for (int i = 0; i < mw; i++) step(nm, P_MEMRD, opc, f3, f7, cmp, 1'b0);
            step(nm, P_MEMRD, opc, f3, f7, cmp, 1'b1);
            step(nm, P_MEMWB, opc, f3, f7, cmp, r);
        end else if (opc == T_STORE) begin
            step(nm, P_MEMADR, opc, f3, f7, cmp, r);
            for (int i = 0; i < mw; i++) step(nm, P_MEMWR, opc, f3, f7, cmp, 1'b0);
            step(nm, P_MEMWR, opc, f3, f7, cmp, 1'b1);
        end else if (opc == T_R || opc == T_IMM || opc == T_LUI || opc == T_AUIPC) begin
            step(nm, (opc == T_R) ? P_EXR : (opc == T_IMM) ? P_EXI : (opc == T_LUI) ? P_LUI : P_AUIPC,
                 opc, f3, f7, cmp, r);
            step(nm, P_ALUWB, opc, f3, f7, cmp, r);
        end else if (opc == T_BR) begin
            step(nm, (f3 == 3'd2 || f3 == 3'd3) ? P_ERR : P_BR, opc, f3, f7, cmp, r);
        end else if (opc == T_JAL || opc == T_JALR) begin
            if (opc == T_JALR) step(nm, P_JALR, opc, f3, f7, cmp, r);
            step(nm, P_JAL, opc, f3, f7, cmp, r);
            step(nm, P_ALUWB, opc, f3, f7, cmp, r);
        end else begin
            step(nm, P_ERR, opc, f3, f7, cmp, r);
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            m_n = nq.pop_front();
            chk({m_n, " state"}, 32'(bus0.state_dbg), 32'(m_e.st));
            chk({m_n, " strobes"}, 32'({bus0.PCWrite, bus0.MemWrite, bus0.IRWrite, bus0.RegWrite, bus0.illegal}),
                32'({m_e.pcw, m_e.mw, m_e.irw, m_e.rw, m_e.ill}));
            chk({m_n, " ALUCtrl"}, 32'(bus0.ALUCtrl), 32'(m_e.aluc));
            if (m_e.care[4]) chk({m_n, " ImmSrc"}, 32'(bus0.ImmSrc), 32'(m_e.imm));
            if (m_e.care[0]) chk({m_n, " AdrSrc"}, 32'(bus0.AdrSrc), 32'(m_e.adr));
            if (m_e.care[1]) chk({m_n, " ResultSrc"}, 32'(bus0.ResultSrc), 32'(m_e.rs));
            if (m_e.care[2]) chk({m_n, " ALUSrcA"}, 32'(bus0.ALUSrcA), 32'(m_e.sa));
            if (m_e.care[3]) chk({m_n, " ALUSrcB"}, 32'(bus0.ALUSrcB), 32'(m_e.sb));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [11];
        ops = '{T_LOAD, T_STORE, T_R, T_IMM, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC, T_FENCE, T_SYS};
        rst_n = 1'b0; rst1_n = 1'b0;
        bus0.opcode = T_R; bus0.funct3 = 3'd0; bus0.funct7b5 = 1'b0;
        bus0.Comparison = 1'b0; bus0.mem_ready = 1'b1;
        bus1.opcode = T_FENCE; bus1.funct3 = 3'd0; bus1.funct7b5 = 1'b0;
        bus1.Comparison = 1'b0; bus1.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", 32'(bus0.state_dbg), 32'(S_FETCH));
        chk("reset strobes", 32'({bus0.PCWrite, bus0.MemWrite, bus0.IRWrite, bus0.RegWrite, bus0.illegal}), 32'd0);
        chk("reset selects", 32'({bus0.AdrSrc, bus0.ALUSrcA, bus0.ALUSrcB, bus0.ResultSrc}), 32'({1'b0, 2'd0, 2'd2, 2'd2}));
        bus0.mem_ready = 1'b0;
        rst_n = 1'b1;

        run_instr("add",   T_R,    3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("sub",   T_R,    3'd0, 1'b1, 1'b1, 0, 0);
        run_instr("srai",  T_IMM,  3'd5, 1'b1, 1'b0, 0, 0);
        run_instr("addi",  T_IMM,  3'd0, 1'b1, 1'b0, 0, 0);
        run_instr("bne1",  T_BR,   3'd1, 1'b0, 1'b1, 0, 0);
        run_instr("bne0",  T_BR,   3'd1, 1'b0, 1'b0, 0, 0);
        run_instr("lw",    T_LOAD, 3'd2, 1'b0, 1'b0, 2, 3);
        run_instr("sw",    T_STORE,3'd2, 1'b0, 1'b0, 1, 2);
        run_instr("jalr",  T_JALR, 3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("jal",   T_JAL,  3'd0, 1'b0, 1'b1, 0, 0);
        run_instr("lui",   T_LUI,  3'd3, 1'b1, 1'b0, 0, 0);
        run_instr("auipc", T_AUIPC,3'd7, 1'b0, 1'b0, 0, 0);
        run_instr("fence", T_FENCE,3'd0, 1'b0, 1'b0, 0, 0);
        run_instr("br010", T_BR,   3'd2, 1'b0, 1'b1, 0, 0);
        for (int n = 0; n < 80; n++) begin
            run_instr("rand", ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Reset while a store is waiting on memory.
        run_instr("swrst", T_STORE, 3'd2, 1'b0, 1'b0, 0, 0);
        step("swrst", P_FETCH, T_STORE, 3'd2, 1'b0, 1'b0, 1'b1);
        step("swrst", P_DEC, T_STORE, 3'd2, 1'b0, 1'b0, 1'b0);
        step("swrst", P_MEMADR, T_STORE, 3'd2, 1'b0, 1'b0, 1'b0);
        step("swrst", P_MEMWR, T_STORE, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        chk("queue drained", 32'(q.size()), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst MemWrite", 32'(bus0.MemWrite), 32'd0);
        chk("rst state", 32'(bus0.state_dbg), 32'(S_FETCH));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr("after rst", T_R, 3'd4, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        chk("queue drained 2", 32'(q.size()), 32'd0);

        // Halting variant: in reset with mem_ready high, then parked in ERR.
        chk("halt in reset IRWrite", 32'(bus1.IRWrite), 32'd0);
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("halt illegal", 32'(bus1.illegal), 32'd1);
            chk("halt state", 32'(bus1.state_dbg), 32'(S_ERR));
        end
        rst1_n = 1'b0;
        #1;
        chk("halt rst illegal", 32'(bus1.illegal), 32'd0);
        chk("halt rst state", 32'(bus1.state_dbg), 32'(S_FETCH));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
